// File: rtl/key_route_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_route_ctrl_if
//   Bundles the control, handshake and splitter-drive signals of
//   key_route_ctrl so the sequencer and its environment connect through one
//   port.
//
//   Signals:
//     start, abort              top-level control requests (single-cycle)
//     line_in                   serial key line, idle-high, asynchronous
//     rx_byte_done, proc_done,
//     tx_byte_done              downstream handshake pulses
//     sel[1:0], en              splitter selector and enable
//     busy, done, timeout_err   status
//     byte_cnt[CNT_W-1:0]       bytes completed in the current phase
//
//   Modports:
//     master  drives control/handshake inputs, observes status (environment)
//     slave   the sequencer itself
// -----------------------------------------------------------------------------
interface key_route_ctrl_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             start;
    logic             abort;
    logic             line_in;
    logic             rx_byte_done;
    logic             proc_done;
    logic             tx_byte_done;
    logic [1:0]       sel;
    logic             en;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] byte_cnt;

    modport master (
        output start, abort, line_in, rx_byte_done, proc_done, tx_byte_done,
        input  sel, en, busy, done, timeout_err, byte_cnt
    );

    modport slave (
        input  start, abort, line_in, rx_byte_done, proc_done, tx_byte_done,
        output sel, en, busy, done, timeout_err, byte_cnt
    );

endinterface

// File: rtl/key_route_ctrl.sv
// -----------------------------------------------------------------------------
// key_route_ctrl
//   Sequencer for the serial key-line splitter. Routes one input line through
//   the receive, process and transmit phases in order, counting completed
//   bytes per phase from the downstream handshake pulses. Route changes
//   between phases only happen after the line has been idle-high for
//   GUARD_CYCLES consecutive synchronized samples, so a frame is never cut.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    key_route_ctrl_if.slave:
//              in : start, abort, line_in, rx_byte_done, proc_done,
//                   tx_byte_done
//              out: sel (00 idle, 01 Rx, 10 P, 11 Tx), en, busy, done,
//                   timeout_err, byte_cnt
//
//   Optional build macro KEY_ROUTE_TIMEOUT_EN:
//     defined   - a watchdog in RX, PROC and TX returns to IDLE after
//                 TIMEOUT_CYCLES cycles without progress and sets the sticky
//                 timeout_err (cleared by the next accepted start).
//     undefined - no watchdog; timeout_err is tied low and TIMEOUT_CYCLES is
//                 unused.
// -----------------------------------------------------------------------------
module key_route_ctrl #(
    parameter int unsigned RX_BYTES       = 16,
    parameter int unsigned TX_BYTES       = 16,
    parameter int unsigned GUARD_CYCLES   = 8,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic             clk,
    input logic             rst_n,
    key_route_ctrl_if.slave bus
);

    localparam int unsigned       GuardW   = $clog2(GUARD_CYCLES + 1);
    localparam logic [GuardW-1:0] GuardMax = GuardW'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0]  RxLast   = CNT_W'(RX_BYTES);
    localparam logic [CNT_W-1:0]  TxLast   = CNT_W'(TX_BYTES);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRx     = 3'd1,
        StGuardP = 3'd2,
        StProc   = 3'd3,
        StGuardT = 3'd4,
        StTx     = 3'd5,
        StDone   = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic [GuardW-1:0]  guard_q, guard_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               guard_entry;
    logic [1:0]         sel;
    logic               en, busy, done;

    assign cnt_inc = byte_cnt_q + CNT_W'(1);

    // -------------------------------------------------------------------------
    // Optional watchdog
    // -------------------------------------------------------------------------
`ifdef KEY_ROUTE_TIMEOUT_EN
    localparam int unsigned    WdW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           watched, kick, wd_fire, start_ok;
    logic           err_q, err_d;

    assign watched  = (state_q == StRx) || (state_q == StProc) || (state_q == StTx);
    // Only a handshake the current state consumes counts as progress.
    assign kick     = ((state_q == StRx)   && bus.rx_byte_done) ||
                      ((state_q == StProc) && bus.proc_done)    ||
                      ((state_q == StTx)   && bus.tx_byte_done);
    // wd_q counts cycles since entry/last kick; firing on TIMEOUT_CYCLES-1
    // leaves the state exactly TIMEOUT_CYCLES cycles after the last progress.
    assign wd_fire  = watched && !kick && (wd_q == WdLast);
    assign start_ok = (state_q == StIdle) && bus.start && !bus.abort;

    always_comb begin
        wd_d = wd_q + WdW'(1);
        if ((state_d != state_q) || kick || !watched) begin
            wd_d = '0;
        end
    end

    always_comb begin
        err_d = err_q;
        if (wd_fire && !bus.abort) begin
            err_d = 1'b1;
        end else if (start_ok) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign bus.timeout_err = err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and byte counter
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StRx;
                    byte_cnt_d = '0;
                end
            end
            StRx: begin
                if (bus.rx_byte_done) begin
                    if (cnt_inc == RxLast) begin
                        state_d    = StGuardP;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = cnt_inc;
                    end
                end
            end
            StGuardP: begin
                if (guard_q == GuardMax) state_d = StProc;
            end
            StProc: begin
                if (bus.proc_done) state_d = StGuardT;
            end
            StGuardT: begin
                if (guard_q == GuardMax) state_d = StTx;
            end
            StTx: begin
                if (bus.tx_byte_done) begin
                    if (cnt_inc == TxLast) begin
                        state_d    = StDone;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = cnt_inc;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d    = StIdle;
                byte_cnt_d = '0;
            end
        endcase

`ifdef KEY_ROUTE_TIMEOUT_EN
        if (wd_fire) begin
            state_d    = StIdle;
            byte_cnt_d = '0;
        end
`endif

        // Abort overrides everything, including a start seen in IDLE.
        if (bus.abort) begin
            state_d    = StIdle;
            byte_cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Line guard: consecutive synchronized-high samples, saturating
    // -------------------------------------------------------------------------
    assign guard_entry = ((state_d == StGuardP) || (state_d == StGuardT)) &&
                         (state_d != state_q);

    always_comb begin
        guard_d = guard_q;
        if (guard_entry || !sync2_q) begin
            guard_d = '0;
        end else if (guard_q != GuardMax) begin
            guard_d = guard_q + GuardW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            guard_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= bus.line_in;
            sync2_q    <= sync1_q;
            guard_q    <= guard_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        sel  = 2'b00;
        en   = 1'b1;
        busy = 1'b1;
        done = 1'b0;
        unique case (state_q)
            StIdle: begin
                en   = 1'b0;
                busy = 1'b0;
            end
            StRx, StGuardP: sel = 2'b01;
            StProc, StGuardT: sel = 2'b10;
            StTx: sel = 2'b11;
            StDone: begin
                en   = 1'b0;
                done = 1'b1;
            end
            default: begin
                en   = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    assign bus.sel      = sel;
    assign bus.en       = en;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_key_route_ctrl.sv
module tb_key_route_ctrl;

    localparam int RX = 4;
    localparam int TX = 2;
    localparam int G  = 8;
    localparam int T  = 100;

    logic clk;
    logic rst_n;

    key_route_ctrl_if #(.CNT_W(8)) kr_if ();

    key_route_ctrl #(
        .RX_BYTES(RX),
        .TX_BYTES(TX),
        .GUARD_CYCLES(G),
        .CNT_W(8),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(kr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase index along the route
    // 0 idle, 1 receive, 2 guard before process, 3 process,
    // 4 guard before transmit, 5 transmit, 6 done.
    int sel_tab[7] = '{0, 1, 1, 2, 2, 3, 0};
    int m_ph, m_cnt, m_edge, m_last;
    bit m_err;
    bit lq[$];   // raw line value at each edge
    bit gh[$];   // synchronized samples seen since entering a guard phase

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_err = 0; m_edge = 0; m_last = 0;
        lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
        gh.delete();
    endtask

    task automatic model_step(input bit s, input bit a, input bit ln,
                              input bit rx, input bit pr, input bit tx);
        int nph, ncnt;
        bit nerr, used, ok, kick;
        m_edge++;
        used = lq[$-1];   // two-flop synchronizer: value from two edges ago
        lq.push_back(ln);
        if (lq.size() > 4) void'(lq.pop_front());
        ok = 0;
        if (gh.size() >= G) begin
            ok = 1;
            for (int i = 0; i < G; i++) if (!gh[gh.size()-1-i]) ok = 0;
        end
        kick = (m_ph == 1 && rx) || (m_ph == 3 && pr) || (m_ph == 5 && tx);
        nph = m_ph; ncnt = m_cnt; nerr = m_err;
        if (a) begin
            nph = 0; ncnt = 0;
        end else begin
            case (m_ph)
                0: if (s) begin nph = 1; ncnt = 0; nerr = 0; end
                1: if (rx) begin
                       ncnt = m_cnt + 1;
                       if (ncnt == RX) begin nph = 2; ncnt = 0; end
                   end
                2: if (ok) nph = 3;
                3: if (pr) nph = 4;
                4: if (ok) nph = 5;
                5: if (tx) begin
                       ncnt = m_cnt + 1;
                       if (ncnt == TX) begin nph = 6; ncnt = 0; end
                   end
                default: nph = 0;
            endcase
`ifdef KEY_ROUTE_TIMEOUT_EN
            if ((m_ph == 1 || m_ph == 3 || m_ph == 5) && !kick && (m_edge - m_last) == T) begin
                nph = 0; ncnt = 0; nerr = 1;
            end
`endif
        end
        if ((nph == 1 || nph == 3 || nph == 5) && (nph != m_ph || kick)) m_last = m_edge;
        if ((nph == 2 || nph == 4) && nph != m_ph) gh.delete();
        else if ((m_ph == 2 || m_ph == 4) && nph == m_ph) begin
            gh.push_back(used);
            if (gh.size() > G) void'(gh.pop_front());
        end
        m_ph = nph; m_cnt = ncnt; m_err = nerr;
    endtask

    function automatic logic [13:0] obs();
        return {kr_if.sel, kr_if.en, kr_if.busy, kr_if.done, kr_if.timeout_err, kr_if.byte_cnt};
    endfunction

    function automatic logic [13:0] exp_v();
        logic [1:0] s;
        s = 2'(sel_tab[m_ph]);
        return {s, (m_ph >= 1 && m_ph <= 5), (m_ph != 0), (m_ph == 6), m_err, 8'(m_cnt)};
    endfunction

    task automatic tick(input bit s, input bit a, input bit ln,
                        input bit rx, input bit pr, input bit tx);
        kr_if.start = s; kr_if.abort = a; kr_if.line_in = ln;
        kr_if.rx_byte_done = rx; kr_if.proc_done = pr; kr_if.tx_byte_done = tx;
        @(posedge clk);
        model_step(s, a, ln, rx, pr, tx);
        #1;
        kr_if.start = 0; kr_if.abort = 0;
        kr_if.rx_byte_done = 0; kr_if.proc_done = 0; kr_if.tx_byte_done = 0;
    endtask

    task automatic do_reset();
        kr_if.start = 0; kr_if.abort = 0; kr_if.line_in = 1;
        kr_if.rx_byte_done = 0; kr_if.proc_done = 0; kr_if.tx_byte_done = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        model_reset();
    endtask

    // Drives the pulse the current phase needs until the model reaches target.
    task automatic go_to_phase(input int target);
        for (int i = 0; i < 200 && m_ph != target; i++) begin
            case (m_ph)
                0: tick(1, 0, 1, 0, 0, 0);
                1: tick(0, 0, 1, 1, 0, 0);
                3: tick(0, 0, 1, 0, 1, 0);
                5: tick(0, 0, 1, 0, 0, 1);
                default: tick(0, 0, 1, 0, 0, 0);
            endcase
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_bad++; $display("FAIL reset_values got=%h want=%h", obs(), 14'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            n_cmp++;
            if (obs() !== exp_v()) begin
                n_bad++; $display("FAIL reset_idle got=%h want=%h", obs(), exp_v());
            end
        end
    endtask

    task automatic test_normal_run();
        int lat, dones;
        bit busy_seen_low;
        tick(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if (obs() !== exp_v()) begin
            n_bad++; $display("FAIL normal_start got=%h want=%h", obs(), exp_v());
        end
        for (int b = 0; b < RX; b++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                tick(0, 0, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                n_cmp++;
                if (obs() !== exp_v()) begin
                    n_bad++; $display("FAIL normal_rx_gap got=%h want=%h", obs(), exp_v());
                end
            end
            tick(0, 0, 1, 1, 0, 0);
            n_cmp++;
            if (obs() !== exp_v()) begin
                n_bad++; $display("FAIL normal_rx_byte got=%h want=%h", obs(), exp_v());
            end
        end
        lat = 0;
        while (kr_if.sel !== 2'b10 && lat < 40) begin
            tick(0, 0, 1, 0, 0, 0);
            lat++;
            n_cmp++;
            if (obs() !== exp_v()) begin
                n_bad++; $display("FAIL normal_guard_p got=%h want=%h", obs(), exp_v());
            end
        end
        n_cmp++;
        if (lat != G + 1) begin
            n_bad++; $display("FAIL proc_latency got=%0d want=%0d", lat, G + 1);
        end
        for (int g = $urandom_range(0, 4); g > 0; g--) tick(0, 0, 1, 1, 0, 1);
        tick(0, 0, 1, 0, 1, 0);
        dones = 0;
        busy_seen_low = 0;
        for (int i = 0; i < 60 && !busy_seen_low; i++) begin
            if (m_ph == 5 && ($urandom_range(0, 2) == 0)) tick(0, 0, 1, 1, 1, 1);
            else if (m_ph == 5) tick(0, 0, 1, 0, 0, 0);
            else tick(0, 0, 1, 0, 0, 0);
            if (kr_if.done === 1'b1) dones++;
            if (kr_if.busy === 1'b0) busy_seen_low = 1;
            n_cmp++;
            if (obs() !== exp_v()) begin
                n_bad++; $display("FAIL normal_tail got=%h want=%h", obs(), exp_v());
            end
        end
        n_cmp++;
        if (dones != 1 || !busy_seen_low) begin
            n_bad++; $display("FAIL done_pulse got=%0d/%0d want=1/1", dones, busy_seen_low);
        end
    endtask

    task automatic test_guard_restart();
        int j, k;
        go_to_phase(2);
        j = $urandom_range(3, 6);
        k = 0;
        while (kr_if.sel !== 2'b10 && k < 40) begin
            k++;
            tick(0, 0, (k == j) ? 1'b0 : 1'b1, 0, 0, 0);
            n_cmp++;
            if (obs() !== exp_v()) begin
                n_bad++; $display("FAIL guard_restart_step got=%h want=%h", obs(), exp_v());
            end
        end
        n_cmp++;
        if (k != j + 11) begin
            n_bad++; $display("FAIL guard_restart_latency got=%0d want=%0d", k, j + 11);
        end
        tick(0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_abort();
        for (int v = 0; v < 3; v++) begin
            if (v < 2) begin
                go_to_phase(5);
                tick(0, 0, 1, 0, 0, 1);
                tick(0, 1, 1, 0, 0, (v == 1));
            end else begin
                go_to_phase(3);
                tick(1, 1, 1, 0, 1, 0);
            end
            n_cmp++;
            if ({kr_if.sel, kr_if.en, kr_if.busy, kr_if.done, kr_if.byte_cnt} !== 13'd0) begin
                n_bad++;
                $display("FAIL abort_v%0d got=%h want=0", v,
                         {kr_if.sel, kr_if.en, kr_if.busy, kr_if.done, kr_if.byte_cnt});
            end
            for (int i = 0; i < 3; i++) begin
                tick(0, 0, 1, 0, 0, 0);
                n_cmp++;
                if (obs() !== exp_v()) begin
                    n_bad++; $display("FAIL abort_after_v%0d got=%h want=%h", v, obs(), exp_v());
                end
            end
        end
    endtask

    task automatic test_ignored();
        go_to_phase(1);
        tick(0, 0, 1, 1, 0, 0);
        tick(0, 0, 1, 0, 1, 0);
        tick(1, 0, 1, 0, 0, 1);
        n_cmp++;
        if ({kr_if.sel, kr_if.busy, kr_if.byte_cnt} !== {2'b01, 1'b1, 8'd1}) begin
            n_bad++; $display("FAIL ignored_in_rx got=%h want=%h",
                              {kr_if.sel, kr_if.busy, kr_if.byte_cnt}, {2'b01, 1'b1, 8'd1});
        end
        go_to_phase(3);
        tick(1, 0, 1, 1, 0, 1);
        tick(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if ({kr_if.sel, kr_if.busy, kr_if.byte_cnt} !== {2'b10, 1'b1, 8'd0}) begin
            n_bad++; $display("FAIL ignored_in_proc got=%h want=%h",
                              {kr_if.sel, kr_if.busy, kr_if.byte_cnt}, {2'b10, 1'b1, 8'd0});
        end
        n_cmp++;
        if (obs() !== exp_v()) begin
            n_bad++; $display("FAIL ignored_model got=%h want=%h", obs(), exp_v());
        end
        tick(0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        go_to_phase(1);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 0, 0);
        n_cmp++;
        if (obs() !== exp_v()) begin
            n_bad++; $display("FAIL pre_reset got=%h want=%h", obs(), exp_v());
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_bad++; $display("FAIL async_reset got=%h want=%h", obs(), 14'd0);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        model_reset();
        tick(0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (obs() !== exp_v()) begin
            n_bad++; $display("FAIL post_reset got=%h want=%h", obs(), exp_v());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
            n_cmp++;
            if (obs() !== exp_v()) begin
                n_bad++; $display("FAIL random_cyc%0d got=%h want=%h", i, obs(), exp_v());
            end
        end
        tick(0, 1, 1, 0, 0, 0);
    endtask

    task automatic test_timeout();
        int k;
        tick(0, 1, 1, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0);
`ifdef KEY_ROUTE_TIMEOUT_EN
        k = 0;
        while (kr_if.busy === 1'b1 && k < 150) begin
            k++;
            tick(0, 0, 1, 0, 0, 0);
            n_cmp++;
            if (obs() !== exp_v()) begin
                n_bad++; $display("FAIL timeout_step got=%h want=%h", obs(), exp_v());
            end
        end
        n_cmp++;
        if (k != T || kr_if.timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_fire got=%0d/%b want=%0d/1", k, kr_if.timeout_err, T);
        end
        tick(1, 0, 1, 0, 0, 0);
        n_cmp++;
        if ({kr_if.sel, kr_if.timeout_err} !== 3'b010) begin
            n_bad++; $display("FAIL timeout_clear got=%b want=010", {kr_if.sel, kr_if.timeout_err});
        end
`else
        k = 0;
        for (int i = 0; i < 150; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            k++;
            n_cmp++;
            if (obs() !== exp_v()) begin
                n_bad++; $display("FAIL no_timeout_step%0d got=%h want=%h", k, obs(), exp_v());
            end
        end
        n_cmp++;
        if ({kr_if.sel, kr_if.busy, kr_if.timeout_err} !== 4'b0110) begin
            n_bad++; $display("FAIL no_timeout_hold got=%b want=0110",
                              {kr_if.sel, kr_if.busy, kr_if.timeout_err});
        end
`endif
        tick(0, 1, 1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_guard_restart();
        test_abort();
        test_ignored();
        test_async_reset();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit got=expired want=finished");
        $fatal(1);
    end

endmodule
